// File: rtl/ysyx_210544_csr_seq.sv
// rtl/ysyx_210544_csr_seq.sv - CSR access sequencer for Zicsr ops, trap entry (ECALL/timer) and MRET
// One CSR address per cycle; trap and return state updates are spread over fixed one-cycle steps.
module ysyx_210544_csr_seq #(
  parameter logic [63:0] MTVEC_MASK = 64'hFFFF_FFFF_FFFF_FFFC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [2:0]  i_op,
  input  logic [11:0] i_addr,
  input  logic [63:0] i_src,
  input  logic        i_wr_suppress,
  input  logic [63:0] i_pc,
  output logic        o_csr_ren,
  output logic [11:0] o_csr_addr,
  output logic        o_csr_wen,
  output logic [63:0] o_csr_wdata,
  input  logic [63:0] i_csr_rdata,
  output logic        o_done,
  output logic [63:0] o_rd_data,
  output logic        o_redirect_valid,
  output logic [63:0] o_redirect_pc
);

  localparam logic [2:0]  OP_CSRRW = 3'd0;
  localparam logic [2:0]  OP_CSRRS = 3'd1;
  localparam logic [2:0]  OP_ECALL = 3'd3;
  localparam logic [2:0]  OP_TIMER = 3'd5;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CSR_RMW,
    S_T_MEPC,
    S_T_MCAUSE,
    S_T_MSTATUS,
    S_T_MTVEC,
    S_R_MSTATUS,
    S_R_MEPC,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [11:0] addr_q, addr_d;
  logic [63:0] src_q, src_d;
  logic        sup_q, sup_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] old_q, old_d;
  logic [63:0] rpc_q, rpc_d;

  // Trap entry: MPIE<=MIE, MIE<=0, MPP<=M. Return: MIE<=MPIE, MPIE<=1, MPP stays M-only.
  logic [63:0] trap_mstatus;
  logic [63:0] mret_mstatus;
  assign trap_mstatus = {i_csr_rdata[63:13], 2'b11, i_csr_rdata[10:8], i_csr_rdata[3],
                         i_csr_rdata[6:4], 1'b0, i_csr_rdata[2:0]};
  assign mret_mstatus = {i_csr_rdata[63:13], 2'b11, i_csr_rdata[10:8], 1'b1,
                         i_csr_rdata[6:4], i_csr_rdata[7], i_csr_rdata[2:0]};

  assign o_req_ready = (state_q == S_IDLE) & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= 3'd0;
      addr_q  <= 12'd0;
      src_q   <= 64'd0;
      sup_q   <= 1'b0;
      pc_q    <= 64'd0;
      old_q   <= 64'd0;
      rpc_q   <= 64'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      src_q   <= src_d;
      sup_q   <= sup_d;
      pc_q    <= pc_d;
      old_q   <= old_d;
      rpc_q   <= rpc_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    op_d             = op_q;
    addr_d           = addr_q;
    src_d            = src_q;
    sup_d            = sup_q;
    pc_d             = pc_q;
    old_d            = old_q;
    rpc_d            = rpc_q;
    o_csr_ren        = 1'b0;
    o_csr_addr       = 12'd0;
    o_csr_wen        = 1'b0;
    o_csr_wdata      = 64'd0;
    o_done           = 1'b0;
    o_rd_data        = 64'd0;
    o_redirect_valid = 1'b0;
    o_redirect_pc    = 64'd0;

    case (state_q)
      S_IDLE: begin
        if (i_req_valid) begin
          op_d   = i_op;
          addr_d = i_addr;
          src_d  = i_src;
          sup_d  = i_wr_suppress;
          pc_d   = i_pc;
          case (i_op)
            3'd0, 3'd1, 3'd2: state_d = S_CSR_RMW;
            3'd3, 3'd5:       state_d = S_T_MEPC;
            3'd4:             state_d = S_R_MSTATUS;
            default:          state_d = S_DONE;
          endcase
        end
      end
      S_CSR_RMW: begin
        o_csr_ren  = 1'b1;
        o_csr_addr = addr_q;
        old_d      = i_csr_rdata;
        o_csr_wen  = (op_q == OP_CSRRW) | ~sup_q;
        case (op_q)
          OP_CSRRW: o_csr_wdata = src_q;
          OP_CSRRS: o_csr_wdata = i_csr_rdata | src_q;
          default:  o_csr_wdata = i_csr_rdata & ~src_q;
        endcase
        state_d = S_DONE;
      end
      S_T_MEPC: begin
        o_csr_wen   = 1'b1;
        o_csr_addr  = CSR_MEPC;
        o_csr_wdata = pc_q;
        state_d     = S_T_MCAUSE;
      end
      S_T_MCAUSE: begin
        o_csr_wen   = 1'b1;
        o_csr_addr  = CSR_MCAUSE;
        o_csr_wdata = (op_q == OP_ECALL) ? 64'd11 : 64'h8000_0000_0000_0007;
        state_d     = S_T_MSTATUS;
      end
      S_T_MSTATUS: begin
        o_csr_ren   = 1'b1;
        o_csr_wen   = 1'b1;
        o_csr_addr  = CSR_MSTATUS;
        o_csr_wdata = trap_mstatus;
        state_d     = S_T_MTVEC;
      end
      S_T_MTVEC: begin
        o_csr_ren  = 1'b1;
        o_csr_addr = CSR_MTVEC;
        rpc_d      = i_csr_rdata & MTVEC_MASK;
        state_d    = S_DONE;
      end
      S_R_MSTATUS: begin
        o_csr_ren   = 1'b1;
        o_csr_wen   = 1'b1;
        o_csr_addr  = CSR_MSTATUS;
        o_csr_wdata = mret_mstatus;
        state_d     = S_R_MEPC;
      end
      S_R_MEPC: begin
        o_csr_ren  = 1'b1;
        o_csr_addr = CSR_MEPC;
        rpc_d      = i_csr_rdata;
        state_d    = S_DONE;
      end
      S_DONE: begin
        o_done           = 1'b1;
        o_rd_data        = (op_q <= 3'd2) ? old_q : 64'd0;
        o_redirect_valid = (op_q >= OP_ECALL) && (op_q <= OP_TIMER);
        o_redirect_pc    = o_redirect_valid ? rpc_q : 64'd0;
        state_d          = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_210544_csr_seq.sv
// tb/tb_ysyx_210544_csr_seq.sv - directed self-checking bench for ysyx_210544_csr_seq
// A small CSR file model answers reads combinationally and commits writes on the clock edge.
module tb_ysyx_210544_csr_seq;

  logic        clk;
  logic        rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [2:0]  i_op;
  logic [11:0] i_addr;
  logic [63:0] i_src;
  logic        i_wr_suppress;
  logic [63:0] i_pc;
  logic        o_csr_ren;
  logic [11:0] o_csr_addr;
  logic        o_csr_wen;
  logic [63:0] o_csr_wdata;
  logic [63:0] i_csr_rdata;
  logic        o_done;
  logic [63:0] o_rd_data;
  logic        o_redirect_valid;
  logic [63:0] o_redirect_pc;

  logic [63:0] mstatus, mtvec, mscratch, mepc, mcause;
  int checks = 0;
  int failures = 0;
  int wen_count = 0;
  int acc_count = 0;
  int done_count = 0;

  int          r_lat;
  logic        r_got;
  logic [63:0] r_rd;
  logic        r_rv;
  logic [63:0] r_rpc;

  ysyx_210544_csr_seq dut (
    .clk              (clk),
    .rst              (rst),
    .i_req_valid      (i_req_valid),
    .o_req_ready      (o_req_ready),
    .i_op             (i_op),
    .i_addr           (i_addr),
    .i_src            (i_src),
    .i_wr_suppress    (i_wr_suppress),
    .i_pc             (i_pc),
    .o_csr_ren        (o_csr_ren),
    .o_csr_addr       (o_csr_addr),
    .o_csr_wen        (o_csr_wen),
    .o_csr_wdata      (o_csr_wdata),
    .i_csr_rdata      (i_csr_rdata),
    .o_done           (o_done),
    .o_rd_data        (o_rd_data),
    .o_redirect_valid (o_redirect_valid),
    .o_redirect_pc    (o_redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    i_csr_rdata = 64'd0;
    case (o_csr_addr)
      12'h300: i_csr_rdata = mstatus;
      12'h305: i_csr_rdata = mtvec;
      12'h340: i_csr_rdata = mscratch;
      12'h341: i_csr_rdata = mepc;
      12'h342: i_csr_rdata = mcause;
      default: i_csr_rdata = 64'd0;
    endcase
  end

  always @(posedge clk) begin
    if (o_csr_wen) begin
      wen_count++;
      case (o_csr_addr)
        12'h300: mstatus  <= o_csr_wdata;
        12'h305: mtvec    <= o_csr_wdata;
        12'h340: mscratch <= o_csr_wdata;
        12'h341: mepc     <= o_csr_wdata;
        12'h342: mcause   <= o_csr_wdata;
        default: ;
      endcase
    end
    if (!rst && i_req_valid && o_req_ready) acc_count++;
    if (o_done) done_count++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic [2:0] op, input logic [11:0] addr, input logic [63:0] src,
                        input logic sup, input logic [63:0] pc, input logic hold);
    @(negedge clk);
    i_op = op; i_addr = addr; i_src = src; i_wr_suppress = sup; i_pc = pc;
    i_req_valid = 1'b1;
    wen_count = 0;
    acc_count = 0;
    check("ready_before", {63'd0, o_req_ready}, 64'd1);
    @(posedge clk);
    #1;
    if (!hold) i_req_valid = 1'b0;
    r_lat = 0; r_got = 1'b0; r_rd = 64'd0; r_rv = 1'b0; r_rpc = 64'd0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (o_done) begin
        r_got = 1'b1; r_lat = k; r_rd = o_rd_data; r_rv = o_redirect_valid; r_rpc = o_redirect_pc;
        break;
      end
    end
    i_req_valid = 1'b0;
    check("done_seen", {63'd0, r_got}, 64'd1);
  endtask

  initial begin
    rst = 1'b0; i_req_valid = 1'b0; i_op = 3'd0; i_addr = 12'd0; i_src = 64'd0;
    i_wr_suppress = 1'b0; i_pc = 64'd0;
    mstatus = 64'h1800; mtvec = 64'h0; mscratch = 64'h55; mepc = 64'h0; mcause = 64'h0;
    #2 rst = 1'b1;
    #1;
    check("rst_ready", {63'd0, o_req_ready}, 64'd0);
    check("rst_done", {63'd0, o_done}, 64'd0);
    check("rst_wen", {63'd0, o_csr_wen}, 64'd0);
    check("rst_rd_data", o_rd_data, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_rst", {63'd0, o_req_ready}, 64'd1);

    // CSRRW mscratch
    do_req(3'd0, 12'h340, 64'h1234, 1'b0, 64'd0, 1'b0);
    check("csrrw_lat", r_lat, 2);
    check("csrrw_rd", r_rd, 64'h55);
    check("csrrw_mscratch", mscratch, 64'h1234);
    check("csrrw_wcount", wen_count, 1);
    check("csrrw_redir", {63'd0, r_rv}, 64'd0);

    // CSRRS with suppressed write
    do_req(3'd1, 12'h300, 64'h8, 1'b1, 64'd0, 1'b0);
    check("csrrs_sup_rd", r_rd, 64'h1800);
    check("csrrs_sup_wcount", wen_count, 0);
    check("csrrs_sup_mstatus", mstatus, 64'h1800);

    do_req(3'd1, 12'h340, 64'hF00, 1'b0, 64'd0, 1'b0);
    check("csrrs_rd", r_rd, 64'h1234);
    check("csrrs_mscratch", mscratch, 64'h1F34);

    do_req(3'd2, 12'h340, 64'h0F0F, 1'b0, 64'd0, 1'b0);
    check("csrrc_rd", r_rd, 64'h1F34);
    check("csrrc_mscratch", mscratch, 64'h1030);

    // CSRRW ignores the suppress flag
    do_req(3'd0, 12'h340, 64'hABCD, 1'b1, 64'd0, 1'b0);
    check("csrrw_sup_wcount", wen_count, 1);
    check("csrrw_sup_mscratch", mscratch, 64'hABCD);

    // ECALL
    mstatus = 64'h1808; mtvec = 64'h8000_0003;
    do_req(3'd3, 12'h0, 64'd0, 1'b0, 64'h8000_0100, 1'b0);
    check("ecall_lat", r_lat, 5);
    check("ecall_mepc", mepc, 64'h8000_0100);
    check("ecall_mcause", mcause, 64'd11);
    check("ecall_mstatus", mstatus, 64'h1880);
    check("ecall_redir_v", {63'd0, r_rv}, 64'd1);
    check("ecall_redir_pc", r_rpc, 64'h8000_0000);
    check("ecall_rd", r_rd, 64'd0);
    check("ecall_wcount", wen_count, 3);

    // MRET
    mepc = 64'h8000_0104;
    do_req(3'd4, 12'h0, 64'd0, 1'b0, 64'd0, 1'b0);
    check("mret_lat", r_lat, 3);
    check("mret_mstatus", mstatus, 64'h1888);
    check("mret_redir_v", {63'd0, r_rv}, 64'd1);
    check("mret_redir_pc", r_rpc, 64'h8000_0104);
    check("mret_wcount", wen_count, 1);

    // Timer interrupt with valid held high; bit 63 of mstatus must pass through
    mstatus = 64'h8000_0000_0000_1888; mtvec = 64'h8000_0100;
    do_req(3'd5, 12'h0, 64'd0, 1'b0, 64'h8000_0200, 1'b1);
    check("timer_lat", r_lat, 5);
    check("timer_mcause", mcause, 64'h8000_0000_0000_0007);
    check("timer_mepc", mepc, 64'h8000_0200);
    check("timer_mstatus", mstatus, 64'h8000_0000_0000_1880);
    check("timer_redir_pc", r_rpc, 64'h8000_0100);
    check("timer_accepts", acc_count, 1);

    // Reserved opcode
    do_req(3'd6, 12'h340, 64'h1, 1'b0, 64'h4, 1'b0);
    check("rsvd_lat", r_lat, 1);
    check("rsvd_rd", r_rd, 64'd0);
    check("rsvd_redir", {63'd0, r_rv}, 64'd0);
    check("rsvd_wcount", wen_count, 0);

    // Reset while in T_MCAUSE
    mcause = 64'h99; mstatus = 64'h1808;
    @(negedge clk);
    i_op = 3'd3; i_pc = 64'h8000_0300; i_req_valid = 1'b1;
    wen_count = 0;
    @(posedge clk);
    #1 i_req_valid = 1'b0;
    @(posedge clk);
    #1;
    done_count = 0;
    #2 rst = 1'b1;
    #1;
    check("abort_wen", {63'd0, o_csr_wen}, 64'd0);
    check("abort_ren", {63'd0, o_csr_ren}, 64'd0);
    check("abort_addr", {52'd0, o_csr_addr}, 64'd0);
    check("abort_wdata", o_csr_wdata, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_done", done_count, 0);
    check("abort_mepc", mepc, 64'h8000_0300);
    check("abort_mcause", mcause, 64'h99);
    check("abort_mstatus", mstatus, 64'h1808);
    check("abort_wcount", wen_count, 1);
    check("abort_ready", {63'd0, o_req_ready}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
